// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF sync, debounce FSM and press/release pulses per channel; auto-repeat with BTN_AUTOREPEAT_EN
module button_conditioner #(
  parameter int N_BTN = 3,
  parameter int CNT_W = 16,
  parameter int DB_CYCLES = 50000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int RPT_W = 24,
  parameter int RPT_DELAY = 5000000,
  parameter int RPT_PERIOD = 1000000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  typedef enum logic [1:0] {STABLE_LO, ARM_HI, STABLE_HI, ARM_LO} state_t;
  logic [N_BTN-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic lvl, prs, rel, done;
    assign done = cnt == CNT_W'(DB_CYCLES - 1);
    assign btn_level[g] = lvl;
    assign btn_press[g] = prs;
    assign btn_release[g] = rel;
`ifdef BTN_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt;
`endif
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state <= STABLE_LO;
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt <= '0;
`endif
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        case (state)
          STABLE_LO: if (sync2[g]) state <= ARM_HI;
          STABLE_HI: if (!sync2[g]) state <= ARM_LO;
          ARM_HI:
            if (!sync2[g]) begin
              state <= STABLE_LO;
              cnt <= '0;
            end else if (done) begin
              state <= STABLE_HI;
              cnt <= '0;
              lvl <= 1'b1;
              prs <= 1'b1;
            end else cnt <= cnt + 1'b1;
          ARM_LO:
            if (sync2[g]) begin
              state <= STABLE_HI;
              cnt <= '0;
            end else if (done) begin
              state <= STABLE_LO;
              cnt <= '0;
              lvl <= 1'b0;
              rel <= 1'b1;
            end else cnt <= cnt + 1'b1;
        endcase
`ifdef BTN_AUTOREPEAT_EN
        if (state == ARM_HI && sync2[g] && done) rpt <= RPT_W'(RPT_DELAY - 1);
        else if (!lvl || (state == ARM_LO && !sync2[g] && done)) rpt <= '0;
        else if (rpt == '0) begin
          rpt <= RPT_W'(RPT_PERIOD - 1);
          prs <= 1'b1;
        end else rpt <= rpt - 1'b1;
`endif
      end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: vector table plus scoreboard checks of debounce, pulses, reset and auto-repeat
module tb_button_conditioner;
  localparam int N = 1000;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  typedef int trip_t [3];
  typedef struct {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    int k;
    string tag;
  } vec_t;
  typedef struct packed {
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } out_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] btn_raw = '0;
  logic [2:0] btn_level, btn_press, btn_release;
  int passed = 0;
  int total = 0;
  out_t sb[$];
  vec_t tbl[$];
  int pat[11] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
  always #5 clk = ~clk;
  button_conditioner #(
    .N_BTN(3),
    .CNT_W(16),
    .DB_CYCLES(4)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .RPT_W(24),
    .RPT_DELAY(RD),
    .RPT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );
  function automatic vec_t mk(logic [2:0] raw, int k, trip_t p, trip_t r, string tag);
    vec_t v;
    v.raw = raw;
    v.k = k;
    v.tag = tag;
    v.lvl = '0;
    v.prs = '0;
    v.rel = '0;
    for (int c = 0; c < 3; c++) begin
      v.lvl[c] = k >= p[c] && k < r[c];
      v.rel[c] = k == r[c];
      v.prs[c] = k == p[c] || (AR && k >= p[c] + RD && (k - p[c] - RD) % RP == 0 && k < r[c]);
    end
    return v;
  endfunction
  task automatic check(input out_t e, input string tag, input int k);
    out_t a;
    a = {btn_level, btn_press, btn_release};
    total++;
    if (a === e) passed++;
    else $display("FAIL %s edge %0d: got lvl/prs/rel=%b/%b/%b, want %b/%b/%b",
                  tag, k, a.lvl, a.prs, a.rel, e.lvl, e.prs, e.rel);
  endtask
  task automatic step(input vec_t v);
    out_t e;
    btn_raw = v.raw;
    sb.push_back('{v.lvl, v.prs, v.rel});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check(e, v.tag, v.k);
  endtask
  task automatic run(input logic [2:0] raw, input int n, input trip_t p, input trip_t r, input string tag);
    for (int k = 0; k < n; k++) step(mk(raw, k, p, r, tag));
  endtask
  initial begin
    for (int k = 0; k < 20; k++) tbl.push_back(mk(3'b010, k, '{N, 6, N}, '{N, N, N}, "press_ch1"));
    for (int k = 0; k < 10; k++) tbl.push_back(mk(3'b000, k, '{N, -14, N}, '{N, 6, N}, "release_ch1"));
    for (int k = 0; k < 26; k++)
      tbl.push_back(mk({2'b00, k < 11 ? pat[k] == 1 : k < 16}, k, '{12, N, N}, '{22, N, N}, "bounce_ch0"));
    run(3'b111, 1, '{N, N, N}, '{N, N, N}, "in_reset");
    run(3'b000, 1, '{N, N, N}, '{N, N, N}, "in_reset");
    run(3'b101, 1, '{N, N, N}, '{N, N, N}, "in_reset");
    run(3'b010, 1, '{N, N, N}, '{N, N, N}, "in_reset");
    btn_raw = '0;
    rst_n = 1'b1;
    run(3'b000, 20, '{N, N, N}, '{N, N, N}, "idle");
    foreach (tbl[i]) step(tbl[i]);
    run(3'b101, 8, '{6, N, 6}, '{N, N, N}, "dual_press");
    run(3'b000, 8, '{-2, N, -2}, '{6, N, 6}, "dual_release");
    run(3'b101, 3, '{N, N, N}, '{N, N, N}, "pre_reset");
    rst_n = 1'b0;
    run(3'b101, 1, '{N, N, N}, '{N, N, N}, "mid_reset");
    rst_n = 1'b1;
    run(3'b101, 9, '{6, N, 6}, '{N, N, N}, "post_reset");
    run(3'b000, 8, '{-3, N, -3}, '{6, N, 6}, "post_release");
    run(3'b100, 30, '{N, N, 6}, '{N, N, N}, "hold_ch2");
    rst_n = 1'b0;
    #1;
    check('0, "async_clear", 0);
    run(3'b000, 2, '{N, N, N}, '{N, N, N}, "held_reset");
    rst_n = 1'b1;
    run(3'b000, 10, '{N, N, N}, '{N, N, N}, "final_idle");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
